// File: rtl/comar_pkg.sv
// Shared constants for the 2-share COMAR gadget sequencer: mask word width,
// share count, gadget latency and the split of r between the two gadget stages.
package comar_pkg;

  localparam int MASK_W     = 6;
  localparam int SHARES     = 2;
  localparam int GADGET_LAT = 2;

  localparam int R_STAGE1_LO = 0;
  localparam int R_STAGE1_HI = 1;
  localparam int R_STAGE2_LO = 2;
  localparam int R_STAGE2_HI = 5;

endpackage

// File: rtl/comar_mask_fifo.sv
// Synchronous DEPTH x MASK_W FIFO holding fresh-mask words; head is the word
// at the read pointer and is valid whenever empty is low.
module comar_mask_fifo
  import comar_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [MASK_W-1:0] din,
  output logic [MASK_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [MASK_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              wr_en;
  logic              rd_en;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only; validity is tracked by the pointers above.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/comar_mask_scheduler.sv
// Issue sequencer and fresh-mask manager for one 2-share COMAR gadget with two
// register stages. Optional statistics counters: define COMAR_MASK_STATS_EN.
module comar_mask_scheduler
  import comar_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int REUSE_MAX = 2,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rng_valid,
  input  logic [MASK_W-1:0] rng_data,
  output logic              rng_ready,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [SHARES-1:0] op_a,
  input  logic [SHARES-1:0] op_b,
  input  logic              op_common,
  output logic [SHARES-1:0] g_a,
  output logic [SHARES-1:0] g_b,
  output logic [MASK_W-1:0] g_r,
  output logic              g_common,
  input  logic [SHARES-1:0] g_c,
  output logic              res_valid,
  output logic [SHARES-1:0] res_c,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  mask_cnt
);

  localparam int          R2_W       = R_STAGE2_HI - R_STAGE2_LO + 1;
  localparam logic [3:0]  REUSE_LAST = 4'(REUSE_MAX - 1);

  logic              fifo_full;
  logic              fifo_empty;
  logic [MASK_W-1:0] head;
  logic              push;
  logic              pop;
  logic              issue;
  logic [3:0]        reuse_cnt;

  logic              vld_p1;
  logic              vld_p2;
  logic [R2_W-1:0]   r_hi_p1;
  logic              common_p1;
  logic              common_p2;

  // Ready is never forwarded from a same-cycle pop; reset masks both handshakes.
  assign rng_ready = !fifo_full && !rst;
  assign op_ready  = !fifo_empty && !rst;
  assign push      = rng_valid && rng_ready;
  assign issue     = op_valid && op_ready;
  assign pop       = issue && (reuse_cnt == REUSE_LAST);

  comar_mask_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (rng_data),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      reuse_cnt <= '0;
    end else if (issue) begin
      reuse_cnt <= pop ? 4'd0 : reuse_cnt + 4'd1;
    end
  end

  // Stage p0 -> p1: register the upper mask field of the issuing word and the
  // common share, so stage 2 of the gadget sees bits of the same word.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      r_hi_p1   <= '0;
      common_p1 <= 1'b0;
    end else begin
      vld_p1    <= issue;
      r_hi_p1   <= issue ? head[R_STAGE2_HI:R_STAGE2_LO] : '0;
      common_p1 <= issue && op_common;
    end
  end

  // Stage p1 -> p2: result and common output share align with the gadget output.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2    <= 1'b0;
      common_p2 <= 1'b0;
    end else begin
      vld_p2    <= vld_p1;
      common_p2 <= common_p1;
    end
  end

  assign g_a       = issue ? op_a : '0;
  assign g_b       = issue ? op_b : '0;
  assign g_r       = {r_hi_p1, (issue ? head[R_STAGE1_HI:R_STAGE1_LO] : 2'b00)};
  assign g_common  = vld_p2 && common_p2;
  assign res_valid = vld_p2;
  assign res_c     = g_c;

`ifdef COMAR_MASK_STATS_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] mask_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      mask_q  <= '0;
    end else begin
      if (op_valid && !op_ready) stall_q <= sat_inc(stall_q);
      if (pop)                   mask_q  <= sat_inc(mask_q);
    end
  end

  assign stall_cnt = stall_q;
  assign mask_cnt  = mask_q;
`else
  assign stall_cnt = '0;
  assign mask_cnt  = '0;
`endif

endmodule

// File: tb/tb_comar_mask_scheduler.sv
// Directed bench for comar_mask_scheduler: stimulus pushes expected results into
// a scoreboard queue, a negedge monitor pops them whenever res_valid is high.
module tb_comar_mask_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rng_valid = 1'b0;
  logic [5:0] rng_data = 6'd0;
  logic       rng_ready;
  logic       op_valid = 1'b0;
  logic       op_ready;
  logic [1:0] op_a = 2'd0;
  logic [1:0] op_b = 2'd0;
  logic       op_common = 1'b0;
  logic [1:0] g_a;
  logic [1:0] g_b;
  logic [5:0] g_r;
  logic       g_common;
  logic [1:0] g_c = 2'd0;
  logic       res_valid;
  logic [1:0] res_c;
  logic [15:0] stall_cnt;
  logic [15:0] mask_cnt;

  int n_chk   = 0;
  int n_pass  = 0;
  int n_res   = 0;
  int n_issue = 0;
  logic sb[$];

  localparam logic [1:0] LO2  [5] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b00};
  localparam logic [3:0] HI2  [5] = '{4'b0000, 4'b1101, 4'b1101, 4'b0110, 4'b0110};
  localparam logic       RDY2 [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam logic       COM2 [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam logic [5:0] SEQ3 [8] = '{6'h22, 6'h22, 6'h33, 6'h33, 6'h04, 6'h04, 6'h2A, 6'h2A};

  comar_mask_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .rng_valid (rng_valid),
    .rng_data  (rng_data),
    .rng_ready (rng_ready),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_common (op_common),
    .g_a       (g_a),
    .g_b       (g_b),
    .g_r       (g_r),
    .g_common  (g_common),
    .g_c       (g_c),
    .res_valid (res_valid),
    .res_c     (res_c),
    .stall_cnt (stall_cnt),
    .mask_cnt  (mask_cnt)
  );

  always #5 clk = ~clk;

  // Gadget stand-in: a changing c value so the pass-through is observable.
  always @(posedge clk) g_c <= g_c + 2'd1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    op_valid = 1'b0;
    rng_valid = 1'b0;
    @(negedge clk);
    chk("rst_op_ready", 32'(op_ready), 32'd0);
    chk("rst_rng_ready", 32'(rng_ready), 32'd0);
    cyc();
    sb.delete();
    rst = 1'b0;
  endtask

  task automatic drain();
    op_valid = 1'b0;
    rng_valid = 1'b0;
    repeat (4) cyc();
  endtask

  task automatic issue_exp(input logic com);
    op_valid = 1'b1;
    op_common = com;
    sb.push_back(com);
    n_issue++;
  endtask

  always @(negedge clk) begin
    logic exp_com;
    if (res_valid) begin
      n_res++;
      if (sb.size() == 0) begin
        chk("unexpected_res_valid", 32'd1, 32'd0);
      end else begin
        exp_com = sb.pop_front();
        chk("g_common", 32'(g_common), 32'(exp_com));
        chk("res_c", 32'(res_c), 32'(g_c));
      end
    end else begin
      chk("g_common_idle", 32'(g_common), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, expected completion");
    $fatal(1);
  end

  initial begin
    int res0;
    logic [5:0] w;
    logic [5:0] wp;

    // Reset state
    repeat (2) cyc();
    @(negedge clk);
    chk("reset_op_ready", 32'(op_ready), 32'd0);
    chk("reset_rng_ready", 32'(rng_ready), 32'd0);
    chk("reset_g_r", 32'(g_r), 32'd0);
    chk("reset_res_valid", 32'(res_valid), 32'd0);
    chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("reset_mask_cnt", 32'(mask_cnt), 32'd0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("idle_rng_ready", 32'(rng_ready), 32'd1);
    chk("idle_op_ready", 32'(op_ready), 32'd0);
    cyc();

    // Single word, stage split of r and result alignment
    rng_valid = 1'b1;
    rng_data = 6'b101101;
    @(negedge clk);
    chk("t1_rng_ready", 32'(rng_ready), 32'd1);
    cyc();
    rng_valid = 1'b0;
    op_a = 2'b01;
    op_b = 2'b10;
    issue_exp(1'b1);
    @(negedge clk);
    chk("t1_op_ready", 32'(op_ready), 32'd1);
    chk("t1_r_lo", 32'(g_r[1:0]), 32'b01);
    chk("t1_r_hi_t", 32'(g_r[5:2]), 32'd0);
    chk("t1_g_a", 32'(g_a), 32'b01);
    chk("t1_g_b", 32'(g_b), 32'b10);
    cyc();
    op_a = 2'b11;
    op_b = 2'b00;
    issue_exp(1'b0);
    @(negedge clk);
    chk("t1_op_ready2", 32'(op_ready), 32'd1);
    chk("t1_r_lo2", 32'(g_r[1:0]), 32'b01);
    chk("t1_r_hi_t1", 32'(g_r[5:2]), 32'b1011);
    cyc();
    op_valid = 1'b0;
    @(negedge clk);
    chk("t1_empty_op_ready", 32'(op_ready), 32'd0);
    chk("t1_idle_g_a", 32'(g_a), 32'd0);
    chk("t1_idle_r_lo", 32'(g_r[1:0]), 32'd0);
    chk("t1_r_hi_t2", 32'(g_r[5:2]), 32'b1011);
    cyc();
    @(negedge clk);
    chk("t1_r_hi_clear", 32'(g_r[5:2]), 32'd0);
    drain();

    // Two words, five back-to-back requests with reuse of 2
    do_reset();
    rng_valid = 1'b1;
    rng_data = 6'b110110;
    cyc();
    rng_data = 6'b011001;
    cyc();
    rng_valid = 1'b0;
    res0 = n_res;
    for (int i = 0; i < 5; i++) begin
      op_valid = 1'b1;
      op_common = COM2[i];
      op_a = 2'(i);
      op_b = 2'(3 - i);
      if (RDY2[i]) begin
        sb.push_back(COM2[i]);
        n_issue++;
      end
      @(negedge clk);
      chk($sformatf("t2_op_ready_%0d", i), 32'(op_ready), 32'(RDY2[i]));
      chk($sformatf("t2_r_lo_%0d", i), 32'(g_r[1:0]), 32'(LO2[i]));
      chk($sformatf("t2_r_hi_%0d", i), 32'(g_r[5:2]), 32'(HI2[i]));
      chk($sformatf("t2_g_a_%0d", i), 32'(g_a), RDY2[i] ? 32'(op_a) : 32'd0);
      cyc();
    end
    op_valid = 1'b0;
    @(negedge clk);
    chk("t2_r_hi_after", 32'(g_r[5:2]), 32'd0);
    drain();
    chk("t2_res_cycles", 32'(n_res - res0), 32'd4);

    // Full FIFO back-pressure, held word accepted once a pop frees space
    do_reset();
    rng_valid = 1'b1;
    rng_data = 6'h11;
    @(negedge clk); chk("t3_ready_w0", 32'(rng_ready), 32'd1); cyc();
    rng_data = 6'h22;
    @(negedge clk); chk("t3_ready_w1", 32'(rng_ready), 32'd1); cyc();
    rng_data = 6'h33;
    @(negedge clk); chk("t3_ready_w2", 32'(rng_ready), 32'd1); cyc();
    rng_data = 6'h04;
    @(negedge clk); chk("t3_ready_w3", 32'(rng_ready), 32'd1); cyc();
    rng_data = 6'h2A;
    @(negedge clk); chk("t3_full_ready", 32'(rng_ready), 32'd0); cyc();
    @(negedge clk); chk("t3_full_ready_hold", 32'(rng_ready), 32'd0); cyc();
    issue_exp(1'b1);
    @(negedge clk);
    chk("t3_iss0_rng_ready", 32'(rng_ready), 32'd0);
    chk("t3_iss0_r_lo", 32'(g_r[1:0]), 32'b01);
    cyc();
    issue_exp(1'b0);
    @(negedge clk);
    chk("t3_pop_rng_ready", 32'(rng_ready), 32'd0);
    chk("t3_iss1_r_lo", 32'(g_r[1:0]), 32'b01);
    chk("t3_iss1_r_hi", 32'(g_r[5:2]), 32'b0100);
    cyc();
    op_valid = 1'b0;
    @(negedge clk); chk("t3_space_rng_ready", 32'(rng_ready), 32'd1); cyc();
    rng_valid = 1'b0;
    @(negedge clk); chk("t3_refull_rng_ready", 32'(rng_ready), 32'd0); cyc();
    for (int i = 0; i < 8; i++) begin
      w = SEQ3[i];
      wp = (i == 0) ? 6'd0 : SEQ3[i - 1];
      issue_exp(1'(i));
      @(negedge clk);
      chk($sformatf("t3_op_ready_%0d", i), 32'(op_ready), 32'd1);
      chk($sformatf("t3_r_lo_%0d", i), 32'(g_r[1:0]), 32'(w[1:0]));
      chk($sformatf("t3_r_hi_%0d", i), 32'(g_r[5:2]), 32'(wp[5:2]));
      cyc();
    end
    op_valid = 1'b0;
    @(negedge clk);
    chk("t3_drained_op_ready", 32'(op_ready), 32'd0);
    chk("t3_last_r_hi", 32'(g_r[5:2]), 32'b1010);
    drain();

    // Push coinciding with last-reuse pop at occupancy 1
    do_reset();
    rng_valid = 1'b1;
    rng_data = 6'b100111;
    cyc();
    rng_valid = 1'b0;
    issue_exp(1'b1);
    @(negedge clk); chk("t4_r_lo0", 32'(g_r[1:0]), 32'b11); cyc();
    issue_exp(1'b0);
    rng_valid = 1'b1;
    rng_data = 6'b010110;
    @(negedge clk);
    chk("t4_pp_op_ready", 32'(op_ready), 32'd1);
    chk("t4_pp_rng_ready", 32'(rng_ready), 32'd1);
    chk("t4_pp_r_lo", 32'(g_r[1:0]), 32'b11);
    chk("t4_pp_r_hi", 32'(g_r[5:2]), 32'b1001);
    cyc();
    rng_valid = 1'b0;
    issue_exp(1'b1);
    @(negedge clk);
    chk("t4_next_op_ready", 32'(op_ready), 32'd1);
    chk("t4_next_r_lo", 32'(g_r[1:0]), 32'b10);
    chk("t4_next_r_hi", 32'(g_r[5:2]), 32'b1001);
    cyc();
    issue_exp(1'b1);
    @(negedge clk);
    chk("t4_last_op_ready", 32'(op_ready), 32'd1);
    chk("t4_last_r_hi", 32'(g_r[5:2]), 32'b0101);
    cyc();
    op_valid = 1'b0;
    @(negedge clk); chk("t4_empty_op_ready", 32'(op_ready), 32'd0); cyc();
    drain();

    // Reset one cycle after an issue discards the in-flight result
    do_reset();
    rng_valid = 1'b1;
    rng_data = 6'b001110;
    cyc();
    rng_valid = 1'b0;
    op_valid = 1'b1;
    op_common = 1'b1;
    @(negedge clk); chk("t5_op_ready", 32'(op_ready), 32'd1); cyc();
    op_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk); chk("t5_res_valid_rst", 32'(res_valid), 32'd0); cyc();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("t5_res_valid_%0d", i), 32'(res_valid), 32'd0);
      chk($sformatf("t5_op_ready_%0d", i), 32'(op_ready), 32'd0);
      cyc();
    end

    // Statistics counters
    do_reset();
    op_valid = 1'b1;
    repeat (3) begin
      @(negedge clk); chk("t6_stall_op_ready", 32'(op_ready), 32'd0); cyc();
    end
    op_valid = 1'b0;
    rng_valid = 1'b1;
    rng_data = 6'b111000;
    cyc();
    rng_valid = 1'b0;
    issue_exp(1'b0);
    cyc();
    issue_exp(1'b1);
    cyc();
    op_valid = 1'b0;
    @(negedge clk);
`ifdef COMAR_MASK_STATS_EN
    chk("t6_stall_cnt", 32'(stall_cnt), 32'd3);
    chk("t6_mask_cnt", 32'(mask_cnt), 32'd1);
`else
    chk("t6_stall_cnt_off", 32'(stall_cnt), 32'd0);
    chk("t6_mask_cnt_off", 32'(mask_cnt), 32'd0);
`endif
    drain();

    chk("total_results", 32'(n_res), 32'(n_issue));
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
